dual_ram_pp_ctrl: RTL

DUAL_RAM_PP_CTRL -- requirements
Module: dual_ram_pp_ctrl

---
 rtl/dual_ram_pkg.sv | 12 +
 rtl/dual_ram_pp_ptr.sv | 19 +
 rtl/dual_ram_pp_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/dual_ram_pkg.sv
// Shared constants and bank-select encoding
// for the dual-RAM ping-pong controller.
package dual_ram_pkg;
  localparam int DEPTH_D = 8;
  localparam int AW_D    = 3;
  localparam int BEW_D   = 8;

  typedef enum logic {
    BANK_WR_RAM2 = 1'b0,
    BANK_WR_RAM1 = 1'b1
  } bank_t;
endpackage

// File: rtl/dual_ram_pp_ptr.sv
// Wrapping bank pointer with enable,
// synchronous clear and an at-last flag.
module dual_ram_pp_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] ptr,
  output logic          last
);
  always_ff @(posedge clk) begin
    if (clr)     ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
  end

  assign last = (ptr == AW'(DEPTH - 1));
endmodule

// File: rtl/dual_ram_pp_ctrl.sv
// Ping-pong controller: producer fills one
// bank while the consumer drains the other.
module dual_ram_pp_ctrl
  import dual_ram_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int AW    = AW_D,
  parameter int BEW   = BEW_D
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  input  logic [BEW-1:0] wr_be,
  output logic           wr_ready,
  input  logic           rd_req,
  output logic           rd_ready,
  output logic           rd_valid,
  output logic           rd_last,
  output logic           rnw,
  output logic [AW-1:0]  wa,
  output logic [AW-1:0]  ra,
  output logic           din_valid,
  output logic [BEW-1:0] be,
  output logic [15:0]    swap_cnt,
  output logic [7:0]     drop_cnt
);
  bank_t bank;
  logic  w_full;
  logic  r_avail;
  logic  wr_fire;
  logic  rd_fire;
  logic  swap;
  logic  w_last;
  logic  r_last;
  logic  ptr_clr;

  assign wr_ready  = ~rst & ~w_full;
  assign rd_ready  = ~rst & r_avail;
  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = rd_req & rd_ready;
  // Both handshakes are closed while swapping.
  assign swap      = ~rst & w_full & ~r_avail;
  assign din_valid = wr_fire;
  assign be        = wr_fire ? wr_be : '1;
  assign rnw       = bank;
  assign ptr_clr   = rst | swap;

  dual_ram_pp_ptr #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_wptr (
    .clk (clk),
    .clr (ptr_clr),
    .en  (wr_fire),
    .ptr (wa),
    .last(w_last)
  );

  dual_ram_pp_ptr #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_rptr (
    .clk (clk),
    .clr (ptr_clr),
    .en  (rd_fire),
    .ptr (ra),
    .last(r_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bank     <= BANK_WR_RAM1;
      w_full   <= 1'b0;
      r_avail  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      swap_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire & r_last;
      if (swap) begin
        bank     <= (bank == BANK_WR_RAM1) ?
                    BANK_WR_RAM2 : BANK_WR_RAM1;
        w_full   <= 1'b0;
        r_avail  <= 1'b1;
        swap_cnt <= swap_cnt + 16'd1;
      end else begin
        if (wr_fire && w_last) w_full  <= 1'b1;
        if (rd_fire && r_last) r_avail <= 1'b0;
      end
      if (wr_valid && !wr_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule
